period_meter: RTL and testbench

Measures the high time, low time and full period of a slow single-bit periodic input (oscillator output, clock-divider tap, external square wave) in units of the local clock. It is the receiving end of the oscillator model: where the oscillator turns half-period parameters into a waveform, this block turns the waveform back into half-period counts. Results are presented through a valid/ready handshake to a monitor or register block.

---
 rtl/period_meter_pkg.sv | 14 +
 rtl/pm_edge_sync.sv | 63 ++++++
 rtl/period_meter.sv | 133 +++++++++++++
 tb/tb_period_meter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/period_meter_pkg.sv
// Shared types and constants for the period meter: FSM state encoding,
// default counter width and the minimum synchronizer depth.
package period_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pm_state_e;

  localparam int DEFAULT_CW      = 16;
  localparam int MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/pm_edge_sync.sv
// Synchronizes the asynchronous z_in, optionally filters 1-cycle glitches
// (PERIOD_METER_GLITCH_FILTER_EN), and produces single-cycle rise/fall pulses.
module pm_edge_sync
  import period_meter_pkg::*;
#(
  parameter int SYNC_STAGES = MIN_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic z_in,
  output logic rise,
  output logic fall
);

  localparam int STAGES = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;

  logic [STAGES-1:0] sync_q;
  logic              zs;
  logic              zs_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], z_in};
    end
  end

`ifdef PERIOD_METER_GLITCH_FILTER_EN
  // The filtered level only follows the synchronized input once it has
  // held the same value on two consecutive cycles.
  logic sy_d;
  logic zf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sy_d <= 1'b0;
      zf   <= 1'b0;
    end else begin
      sy_d <= sync_q[STAGES-1];
      if (sync_q[STAGES-1] == sy_d) begin
        zf <= sy_d;
      end
    end
  end

  assign zs = zf;
`else
  assign zs = sync_q[STAGES-1];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zs_d <= 1'b0;
    end else begin
      zs_d <= zs;
    end
  end

  assign rise = zs & ~zs_d;
  assign fall = ~zs & zs_d;

endmodule

// File: rtl/period_meter.sv
// Measures high/low/period of a slow input in clk cycles and presents each
// result on a valid/ready port. Optional glitch filter: PERIOD_METER_GLITCH_FILTER_EN.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CW          = DEFAULT_CW,
  parameter int SYNC_STAGES = MIN_SYNC_STAGES
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          z_in,
  input  logic          clear,
  output logic [CW-1:0] hi_cnt,
  output logic [CW-1:0] lo_cnt,
  output logic [CW:0]   period,
  output logic          sat,
  output logic          valid,
  input  logic          ready,
  output logic          overrun,
  output pm_state_e     state_dbg
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic      rise;
  logic      fall;
  pm_state_e state, state_next;
  logic [CW-1:0] hi_ctr, hi_next;
  logic [CW-1:0] lo_ctr, lo_next;
  logic          sat_acc, sat_next;
  logic          complete;

  pm_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .z_in  (z_in),
    .rise  (rise),
    .fall  (fall)
  );

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      hi_ctr  <= '0;
      lo_ctr  <= '0;
      sat_acc <= 1'b0;
    end else begin
      state   <= state_next;
      hi_ctr  <= hi_next;
      lo_ctr  <= lo_next;
      sat_acc <= sat_next;
    end
  end

  // A rise in LOW closes the period and immediately opens the next high phase.
  always_comb begin
    state_next = state;
    hi_next    = hi_ctr;
    lo_next    = lo_ctr;
    sat_next   = sat_acc;
    complete   = 1'b0;
    if (clear) begin
      state_next = IDLE;
      hi_next    = '0;
      lo_next    = '0;
      sat_next   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state_next = HIGH;
            hi_next    = CW'(1);
            lo_next    = '0;
            sat_next   = 1'b0;
          end
        end
        HIGH: begin
          if (fall) begin
            state_next = LOW;
            lo_next    = CW'(1);
          end else if (hi_ctr == CNT_MAX) begin
            sat_next = 1'b1;
          end else begin
            hi_next = hi_ctr + CW'(1);
          end
        end
        LOW: begin
          if (rise) begin
            complete   = 1'b1;
            state_next = HIGH;
            hi_next    = CW'(1);
            lo_next    = '0;
            sat_next   = 1'b0;
          end else if (lo_ctr == CNT_MAX) begin
            sat_next = 1'b1;
          end else begin
            lo_next = lo_ctr + CW'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Handshake: a result transfers on any cycle with valid & ready. valid stays
  // high with stable outputs until then; a completion that finds the port
  // still occupied (valid & ~ready) is dropped and flagged in sticky overrun.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_cnt  <= '0;
      lo_cnt  <= '0;
      period  <= '0;
      sat     <= 1'b0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else if (complete) begin
      if (!valid || ready) begin
        hi_cnt <= hi_ctr;
        lo_cnt <= lo_ctr;
        period <= {1'b0, hi_ctr} + {1'b0, lo_ctr};
        sat    <= sat_acc;
        valid  <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter: a CW=16 instance plus a CW=4 instance
// for saturation; glitch expectations follow PERIOD_METER_GLITCH_FILTER_EN.
module tb_period_meter;
  import period_meter_pkg::*;

`ifdef PERIOD_METER_GLITCH_FILTER_EN
  localparam int EDGE_LAT = 4;
`else
  localparam int EDGE_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        z_in = 1'b0;
  logic        clear = 1'b0;
  logic        ready = 1'b1;
  logic        ready4 = 1'b1;
  logic [15:0] hi_cnt, lo_cnt;
  logic [16:0] period;
  logic        sat, valid, overrun;
  pm_state_e   state_dbg;
  logic [3:0]  hi4, lo4;
  logic [4:0]  period4;
  logic        sat4, valid4, overrun4;
  pm_state_e   state4;

  int n_checks = 0;
  int n_errors = 0;
  bit mon4_en = 1'b0;
  logic [49:0] exp_q[$];
  logic [13:0] exp4_q[$];
  logic [49:0] got, e;
  logic [13:0] got4, e4;

  always #5 clk = ~clk;

  period_meter #(.CW(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .z_in(z_in), .clear(clear),
    .hi_cnt(hi_cnt), .lo_cnt(lo_cnt), .period(period), .sat(sat),
    .valid(valid), .ready(ready), .overrun(overrun), .state_dbg(state_dbg)
  );

  period_meter #(.CW(4), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .z_in(z_in), .clear(clear),
    .hi_cnt(hi4), .lo_cnt(lo4), .period(period4), .sat(sat4),
    .valid(valid4), .ready(ready4), .overrun(overrun4), .state_dbg(state4)
  );

  // Scoreboard for the wide instance: every accepted result is popped and compared.
  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      n_checks++;
      got = {sat, period, lo_cnt, hi_cnt};
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL result_unexpected got hi=%0d lo=%0d period=%0d sat=%0d", hi_cnt, lo_cnt, period, sat);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_errors++;
          $display("FAIL result got hi=%0d lo=%0d period=%0d sat=%0d exp hi=%0d lo=%0d period=%0d sat=%0d",
                   hi_cnt, lo_cnt, period, sat, e[15:0], e[31:16], e[48:32], e[49]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && mon4_en && valid4) begin
      n_checks++;
      got4 = {sat4, period4, lo4, hi4};
      if (exp4_q.size() == 0) begin
        n_errors++;
        $display("FAIL result4_unexpected got hi=%0d lo=%0d period=%0d sat=%0d", hi4, lo4, period4, sat4);
      end else begin
        e4 = exp4_q.pop_front();
        if (got4 !== e4) begin
          n_errors++;
          $display("FAIL result4 got hi=%0d lo=%0d period=%0d sat=%0d exp hi=%0d lo=%0d period=%0d sat=%0d",
                   hi4, lo4, period4, sat4, e4[3:0], e4[7:4], e4[12:8], e4[13]);
        end
      end
    end
  end

  function automatic logic [49:0] mk(input int hi, input int lo);
    logic [16:0] p;
    p = 17'(hi + lo);
    return {1'b0, p, 16'(lo), 16'(hi)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic phase(input logic lvl, input int n);
    z_in = lvl;
    repeat (n) tick();
  endtask

  task automatic push(input int hi, input int lo);
    exp_q.push_back(mk(hi, lo));
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear = 1'b0;
    z_in  = 1'b0;
    ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || exp4_q.size() != 0) && t < 64) begin
      tick();
      t++;
    end
    n_checks++;
    if (exp_q.size() != 0 || exp4_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_drain pending=%0d/%0d required 0/0", name, exp_q.size(), exp4_q.size());
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks += 7;
    if (hi_cnt !== 16'd0) begin n_errors++; $display("FAIL reset_hi got %0d exp 0", hi_cnt); end
    if (lo_cnt !== 16'd0) begin n_errors++; $display("FAIL reset_lo got %0d exp 0", lo_cnt); end
    if (period !== 17'd0) begin n_errors++; $display("FAIL reset_period got %0d exp 0", period); end
    if (sat !== 1'b0) begin n_errors++; $display("FAIL reset_sat got %0b exp 0", sat); end
    if (valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %0b exp 0", valid); end
    if (overrun !== 1'b0) begin n_errors++; $display("FAIL reset_overrun got %0b exp 0", overrun); end
    if (state_dbg !== IDLE) begin n_errors++; $display("FAIL reset_state got %0d exp %0d", state_dbg, IDLE); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    phase(1'b0, 4);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) push(5, 3);
      phase(1'b1, 5);
      phase(1'b0, 3);
    end
    push(5, 3);
    phase(1'b1, 5);
    phase(1'b0, 2);
    drain("back_to_back");
    n_checks++;
    if (overrun !== 1'b0) begin n_errors++; $display("FAIL b2b_overrun got %0b exp 0", overrun); end
  endtask

  task automatic test_overrun();
    apply_reset();
    ready = 1'b0;
    phase(1'b0, 4);
    phase(1'b1, 5);
    phase(1'b0, 3);
    phase(1'b1, 5);
    phase(1'b0, 3);
    n_checks += 2;
    if (valid !== 1'b1) begin n_errors++; $display("FAIL ovr_first_valid got %0b exp 1", valid); end
    if (overrun !== 1'b0) begin n_errors++; $display("FAIL ovr_first_overrun got %0b exp 0", overrun); end
    phase(1'b1, 5);
    phase(1'b0, 3);
    phase(1'b1, 5);
    phase(1'b0, 2);
    n_checks += 5;
    if (valid !== 1'b1) begin n_errors++; $display("FAIL ovr_hold_valid got %0b exp 1", valid); end
    if (hi_cnt !== 16'd5) begin n_errors++; $display("FAIL ovr_hold_hi got %0d exp 5", hi_cnt); end
    if (lo_cnt !== 16'd3) begin n_errors++; $display("FAIL ovr_hold_lo got %0d exp 3", lo_cnt); end
    if (period !== 17'd8) begin n_errors++; $display("FAIL ovr_hold_period got %0d exp 8", period); end
    if (overrun !== 1'b1) begin n_errors++; $display("FAIL ovr_sticky got %0b exp 1", overrun); end
    push(5, 3);
    ready = 1'b1;
    phase(1'b0, 5);
    push(5, 7);
    phase(1'b1, 4);
    phase(1'b0, 3);
    drain("overrun");
    n_checks += 2;
    if (overrun !== 1'b1) begin n_errors++; $display("FAIL ovr_still_set got %0b exp 1", overrun); end
    if (valid !== 1'b0) begin n_errors++; $display("FAIL ovr_valid_drop got %0b exp 0", valid); end
  endtask

  task automatic test_saturation();
    apply_reset();
    mon4_en = 1'b1;
    phase(1'b0, 3);
    phase(1'b1, 20);
    phase(1'b0, 2);
    push(20, 2);
    exp4_q.push_back({1'b1, 5'd17, 4'd2, 4'd15});
    phase(1'b1, 15);
    phase(1'b0, 2);
    push(15, 2);
    exp4_q.push_back({1'b0, 5'd17, 4'd2, 4'd15});
    phase(1'b1, 3);
    phase(1'b0, 2);
    drain("saturation");
    mon4_en = 1'b0;
    n_checks++;
    if (overrun4 !== 1'b0) begin n_errors++; $display("FAIL sat_overrun4 got %0b exp 0", overrun4); end
  endtask

  task automatic test_clear();
    apply_reset();
    phase(1'b0, 4);
    phase(1'b1, 6);
    n_checks++;
    if (state_dbg !== HIGH) begin n_errors++; $display("FAIL clear_pre_state got %0d exp %0d", state_dbg, HIGH); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_checks++;
    if (state_dbg !== IDLE) begin n_errors++; $display("FAIL clear_abort_state got %0d exp %0d", state_dbg, IDLE); end
    phase(1'b1, 4);
    phase(1'b0, 4);
    phase(1'b1, 4);
    phase(1'b0, 4);
    push(4, 4);
    phase(1'b1, 4);
    phase(1'b0, 2);
    drain("clear_abort");
    // Clear coinciding with the rise pulse that would close the period.
    phase(1'b0, 4);
    z_in = 1'b1;
    repeat (EDGE_LAT) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_checks++;
    if (state_dbg !== IDLE) begin n_errors++; $display("FAIL clear_rise_state got %0d exp %0d", state_dbg, IDLE); end
    phase(1'b1, 4);
    phase(1'b0, 4);
    phase(1'b1, 4);
    phase(1'b0, 4);
    push(4, 4);
    phase(1'b1, 4);
    phase(1'b0, 2);
    drain("clear_rise");
  endtask

  task automatic test_reset_mid();
    apply_reset();
    phase(1'b0, 3);
    phase(1'b1, 5);
    phase(1'b0, 3);
    push(5, 3);
    phase(1'b1, 5);
    phase(1'b0, 2);
    drain("reset_mid_pre");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks += 6;
    if (hi_cnt !== 16'd0) begin n_errors++; $display("FAIL rmid_hi got %0d exp 0", hi_cnt); end
    if (lo_cnt !== 16'd0) begin n_errors++; $display("FAIL rmid_lo got %0d exp 0", lo_cnt); end
    if (period !== 17'd0) begin n_errors++; $display("FAIL rmid_period got %0d exp 0", period); end
    if (valid !== 1'b0) begin n_errors++; $display("FAIL rmid_valid got %0b exp 0", valid); end
    if (overrun !== 1'b0) begin n_errors++; $display("FAIL rmid_overrun got %0b exp 0", overrun); end
    if (state_dbg !== IDLE) begin n_errors++; $display("FAIL rmid_state got %0d exp %0d", state_dbg, IDLE); end
    phase(1'b0, 3);
    phase(1'b1, 6);
    phase(1'b0, 2);
    push(6, 2);
    phase(1'b1, 3);
    phase(1'b0, 2);
    drain("reset_mid_post");
  endtask

  task automatic test_glitch();
    apply_reset();
    phase(1'b0, 3);
    phase(1'b1, 3);
    phase(1'b0, 3);
    push(3, 3);
    phase(1'b1, 4);
`ifdef PERIOD_METER_GLITCH_FILTER_EN
    push(10, 6);
`else
    push(4, 1);
    push(5, 6);
`endif
    phase(1'b0, 1);
    phase(1'b1, 5);
    phase(1'b0, 6);
    phase(1'b1, 3);
    phase(1'b0, 2);
    drain("glitch");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_overrun();
    test_saturation();
    test_clear();
    test_reset_mid();
    test_glitch();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
